// File: rtl/gate_model_bist_ctrl.sv
// BIST sequencer: LFSR stimulus into a 14-in/10-out gate model, MISR compaction, golden compare.
// Optional abort input when GM_BIST_ABORT_EN is defined; busy/done are registered state decodes.
module gate_model_bist_ctrl #(
  parameter int          PATTERN_COUNT = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [13:0] SEED          = 14'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef GM_BIST_ABORT_EN
  input  logic        abort,
`endif
  input  logic [15:0] expected_sig,
  input  logic [9:0]  dut_out,
  output logic [13:0] dut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;

  localparam logic [15:0] LAST_VEC  = 16'(PATTERN_COUNT - 1);
  localparam logic [7:0]  LAST_WAIT = 8'(SETTLE_CYCLES - 1);

  state_t      state, next_state;
  logic [13:0] lfsr;
  logic [15:0] misr;
  logic [15:0] cnt;
  logic [7:0]  wait_cnt;
  logic        aborted;
  logic        in_run;
  logic        abort_req;
  logic        load, apply, capture, finish;

  assign in_run = (state == APPLY) || (state == SETTLE) || (state == CAPTURE);

`ifdef GM_BIST_ABORT_EN
  assign abort_req = abort && in_run;
`else
  assign abort_req = 1'b0;
`endif

  assign signature = misr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    apply      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = APPLY;
          load       = 1'b1;
        end
      end
      APPLY: begin
        apply      = 1'b1;
        next_state = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      end
      SETTLE: begin
        if (wait_cnt == LAST_WAIT) next_state = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        next_state = (cnt == LAST_VEC) ? DONE : APPLY;
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // An abort freezes lfsr/misr/cnt so the signature keeps its partial value.
    if (abort_req) begin
      next_state = DONE;
      apply      = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= SEED;
      misr     <= 16'h0000;
      cnt      <= 16'h0000;
      wait_cnt <= 8'h00;
      dut_in   <= 14'h0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      busy <= in_run;
      done <= finish;
      if (load) begin
        lfsr    <= SEED;
        misr    <= 16'h0000;
        cnt     <= 16'h0000;
        pass    <= 1'b0;
        aborted <= 1'b0;
      end
      if (apply) begin
        dut_in   <= lfsr;
        wait_cnt <= 8'h00;
      end
      if (state == SETTLE) wait_cnt <= wait_cnt + 8'h01;
      if (capture) begin
        misr <= {misr[14:0], misr[15] ^ misr[14] ^ misr[12] ^ misr[3]} ^ {6'b0, dut_out};
        lfsr <= {lfsr[12:0], lfsr[13] ^ lfsr[4] ^ lfsr[2] ^ lfsr[0]};
        cnt  <= cnt + 16'h0001;
      end
      if (abort_req) aborted <= 1'b1;
      if (finish) pass <= !aborted && (misr == expected_sig);
    end
  end

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// Directed bench for gate_model_bist_ctrl: three instances with different run lengths/settle times.
// Instance 2 drives a small XOR gate model so signatures depend on the stimulus sequence.
module tb_gate_model_bist_ctrl;

  logic        clk;
  logic        rst;
  logic        start     [3];
  logic        abort     [3];
  logic [15:0] exp_sig   [3];
  logic [9:0]  dout      [3];
  logic [13:0] din       [3];
  logic        busy      [3];
  logic        done      [3];
  logic        pass      [3];
  logic [15:0] sig       [3];
  logic        zero_mode;
  logic [13:0] seq_exp   [4];

  int checks = 0;
  int errors = 0;

  function automatic logic [9:0] gm(input logic [13:0] x);
    return x[9:0] ^ x[13:4];
  endfunction

  function automatic logic [15:0] model_sig(input int pc);
    logic [13:0] l;
    logic [15:0] m;
    l = 14'h0001;
    m = 16'h0000;
    for (int i = 0; i < pc; i++) begin
      m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {6'b0, gm(l)};
      l = {l[12:0], l[13] ^ l[4] ^ l[2] ^ l[0]};
    end
    return m;
  endfunction

  assign dout[0] = 10'h001;
  assign dout[1] = 10'h001;
  assign dout[2] = zero_mode ? 10'h000 : gm(din[2]);

  gate_model_bist_ctrl #(.PATTERN_COUNT(4), .SETTLE_CYCLES(0), .SEED(14'h0001)) u_a (
    .clk(clk), .reset(rst), .start(start[0]),
`ifdef GM_BIST_ABORT_EN
    .abort(abort[0]),
`endif
    .expected_sig(exp_sig[0]), .dut_out(dout[0]), .dut_in(din[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));

  gate_model_bist_ctrl #(.PATTERN_COUNT(2), .SETTLE_CYCLES(2), .SEED(14'h0001)) u_b (
    .clk(clk), .reset(rst), .start(start[1]),
`ifdef GM_BIST_ABORT_EN
    .abort(abort[1]),
`endif
    .expected_sig(exp_sig[1]), .dut_out(dout[1]), .dut_in(din[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));

  gate_model_bist_ctrl u_c (
    .clk(clk), .reset(rst), .start(start[2]),
`ifdef GM_BIST_ABORT_EN
    .abort(abort[2]),
`endif
    .expected_sig(exp_sig[2]), .dut_out(dout[2]), .dut_in(din[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Leaves the caller 1 time unit after the edge that sampled start.
  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done[i] && edges < budget);
  endtask

  initial begin
    int e;
    int n_done;
    logic [15:0] full_sig;

    seq_exp[0] = 14'h0001;
    seq_exp[1] = 14'h0003;
    seq_exp[2] = 14'h0007;
    seq_exp[3] = 14'h000E;
    for (int i = 0; i < 3; i++) begin
      start[i]   = 1'b0;
      abort[i]   = 1'b0;
      exp_sig[i] = 16'h0000;
    end
    zero_mode = 1'b1;
    full_sig  = model_sig(256);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_din",  32'(din[0]),  32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_done", 32'(done[0]), 32'h0);
    chk("rst_pass", 32'(pass[0]), 32'h0);
    chk("rst_sig",  32'(sig[0]),  32'h0);

    // Sequence and cycle timing, PATTERN_COUNT=4, SETTLE_CYCLES=0
    pulse_start(0);
    chk("seq_busy_k", 32'(busy[0]), 32'h0);
    @(posedge clk);
    #1;
    chk("seq_busy_k1", 32'(busy[0]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seq_din%0d", i), 32'(din[0]), 32'(seq_exp[i]));
      chk($sformatf("seq_nodone%0d", i), 32'(done[0]), 32'h0);
      @(posedge clk);
      #1;
    end
    chk("seq_done_k9", 32'(done[0]), 32'h1);
    @(posedge clk);
    #1;
    chk("seq_done_pulse", 32'(done[0]), 32'h0);
    chk("seq_busy_end",   32'(busy[0]), 32'h0);
    chk("seq_din_hold",   32'(din[0]),  32'h000E);

    // Signature with constant response, PATTERN_COUNT=2, SETTLE_CYCLES=2
    exp_sig[1] = 16'h0003;
    pulse_start(1);
    wait_done(1, 100, e);
    chk("sig_edges", 32'(e), 32'd9);
    chk("sig_val", 32'(sig[1]), 32'h0003);
    @(posedge clk);
    #1;
    chk("sig_pass", 32'(pass[1]), 32'h1);
    exp_sig[1] = 16'h0004;
    pulse_start(1);
    chk("sig_pass_clr", 32'(pass[1]), 32'h0);
    wait_done(1, 100, e);
    chk("sig_val2", 32'(sig[1]), 32'h0003);
    @(posedge clk);
    #1;
    chk("sig_fail_pass", 32'(pass[1]), 32'h0);

    // Zero response, default parameters
    zero_mode  = 1'b1;
    exp_sig[2] = 16'h0000;
    pulse_start(2);
    wait_done(2, 2000, e);
    chk("zero_edges", 32'(e), 32'd1025);
    chk("zero_sig", 32'(sig[2]), 32'h0);
    @(posedge clk);
    #1;
    chk("zero_pass", 32'(pass[2]), 32'h1);

    // Start re-pulsed mid-run is ignored
    zero_mode  = 1'b0;
    exp_sig[2] = full_sig;
    pulse_start(2);
    repeat (300) @(posedge clk);
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    wait_done(2, 2000, e);
    chk("restart_edges", 32'(301 + e), 32'd1025);
    chk("restart_sig", 32'(sig[2]), 32'(full_sig));
    @(posedge clk);
    #1;
    chk("restart_pass", 32'(pass[2]), 32'h1);

    // Reset around vector 100, then a clean rerun
    pulse_start(2);
    repeat (401) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy[2]), 32'h0);
    chk("mid_rst_sig",  32'(sig[2]),  32'h0);
    n_done = 0;
    repeat (1100) begin
      @(posedge clk);
      #1;
      if (done[2]) n_done++;
    end
    chk("mid_rst_nodone", 32'(n_done), 32'h0);
    pulse_start(2);
    wait_done(2, 2000, e);
    chk("rerun_edges", 32'(e), 32'd1025);
    chk("rerun_sig", 32'(sig[2]), 32'(full_sig));
    @(posedge clk);
    #1;
    chk("rerun_pass", 32'(pass[2]), 32'h1);

`ifdef GM_BIST_ABORT_EN
    pulse_start(2);
    repeat (41) @(posedge clk);
    @(negedge clk);
    abort[2] = 1'b1;
    @(posedge clk);
    #1;
    abort[2] = 1'b0;
    wait_done(2, 3, e);
    chk("abort_done", 32'(done[2]), 32'h1);
    @(posedge clk);
    #1;
    chk("abort_pass", 32'(pass[2]), 32'h0);
    chk("abort_busy", 32'(busy[2]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
